frame_scheduler: RTL and testbench
==================================

Name: frame_scheduler

Overview:
- Top-level game sequencer for the wall-scroller: one game frame per tick.
- Divides the system clock into a frame tick.
- Per tick, steps the physics datapath and the screen updater through PHYSICS -> SETUP -> DISPLAY, waiting on the updater's done handshake.
- Sits between the switch/key inputs, the wall/dude datapath and the VGA update_screen logic. Supplies one-hot phase levels, start strobes, watchdog and status.

Parameters:
TICK_DIV, 833333, clk cycles per frame tick (60 Hz at 50 MHz); legal range >= 4.
CNT_W, 20, width of tick counter; must hold TICK_DIV-1.
DRAW_TIMEOUT, 20000, max clk cycles in DRAW awaiting draw_done.
TO_W, 15, width of draw watchdog counter; must hold DRAW_TIMEOUT.

Ports:
clk  in  1  system clock (CLOCK_50).
resetn  in  1  asynchronous active-low reset.
go  in  1  start/run switch, level.
pause  in  1  freeze frames when high, level.
endgame  in  1  from datapath, valid in PHYS2 cycle.
draw_done  in  1  from screen updater, 1-cycle pulse or level.
menu  out  1  high in IDLE and OVER.
physics  out  1  high in PHYS1 and PHYS2.
setup  out  1  high in SETUP.
display  out  1  high in DRAW.
draw_start  out  1  1-cycle pulse on SETUP->DRAW transition.
timeout_err  out  1  sticky: a DRAW watchdog expired.
frame_miss  out  1  sticky: tick arrived while a tick was already pending.
frame_cnt  out  16  completed frames since start, wraps 0xFFFF->0.
state  out  3  encoded state for HEX debug.

Behaviour:
- Reset (async, resetn=0):
  - State IDLE; tick counter 0; pending 0; watchdog 0.
  - Outputs: menu=1, others 0; frame_cnt=0; timeout_err=0; frame_miss=0; state=0.
- State encoding: IDLE=0, WAIT=1, PHYS1=2, PHYS2=3, SETUP=4, DRAW=5, OVER=6. menu/physics/setup/display are registered, one-hot by state.
- Tick counter:
  - Free-running in all non-reset states: 0..TICK_DIV-1, then wraps to 0.
  - tick = (count == TICK_DIV-1), internal 1-cycle.
  - Counter is cleared to 0 on the IDLE->WAIT transition.
- Pending flag:
  - Set on tick.
  - Cleared when WAIT advances to PHYS1.
  - If tick and a WAIT->PHYS1 advance occur in the same cycle, pending stays set.
  - If tick occurs while pending is already 1 and no clear happens that cycle, frame_miss <= 1.
- Transitions:
  - IDLE -> WAIT when go=1.
  - WAIT -> PHYS1 when pending=1 and pause=0 and go=1.
  - WAIT -> IDLE when go=0.
  - PHYS1 -> PHYS2 unconditionally. This gives the datapath one cycle of registered collision sampling.
  - PHYS2 -> OVER if endgame=1, else SETUP.
  - SETUP -> DRAW unconditionally; draw_start=1 for exactly that edge's following cycle (first DRAW cycle).
  - DRAW -> WAIT on draw_done=1: frame_cnt <= frame_cnt+1; watchdog cleared.
  - DRAW -> WAIT on watchdog == DRAW_TIMEOUT-1 without draw_done: timeout_err <= 1; frame_cnt unchanged.
  - draw_done takes priority over timeout in the same cycle.
  - OVER -> IDLE when go=0. OVER holds while go=1, so no auto-restart.
- Watchdog:
  - Counts only in DRAW, +1 per cycle.
  - Cleared in every other state.
- Sticky clears:
  - timeout_err, frame_miss and frame_cnt clear on reset.
  - The same three clear on the IDLE->WAIT transition.
- pause:
  - Only gates WAIT->PHYS1; an in-flight frame always completes.
  - Ticks during pause still set pending / frame_miss.
- draw_done outside DRAW is ignored. endgame outside PHYS2 is ignored.
- go=0 mid-frame (PHYS1..DRAW): the frame completes; exit to IDLE occurs from WAIT.
- Async reset mid-DRAW: immediate return to reset values; no draw_start or frame_cnt update.
- Latency: tick to physics=1 is 2 cycles (pending registered, then WAIT->PHYS1).

Test Plan (TICK_DIV=8, DRAW_TIMEOUT=16):
- Reset then go=1 -> menu falls 1 cycle later; first tick at cycle 8 after start; physics high 2 cycles; setup 1 cycle; display plus draw_start pulse. draw_done at DRAW cycle 3 -> frame_cnt=1, back to WAIT.
- endgame=1 during PHYS2 -> no SETUP; state=6, menu=1. Hold go=1 for 20 cycles -> stays OVER. go=0 -> IDLE next cycle.
- No draw_done -> display drops after exactly 16 DRAW cycles; timeout_err=1; frame_cnt unchanged. Next frame's draw_done -> frame_cnt increments; timeout_err remains 1 until go restart.
- draw_done held off 20 cycles, i.e. two ticks pass -> frame_miss=1. The next frame starts immediately from WAIT, since pending is set.
- pause=1 across 3 ticks -> no physics pulses, frame_miss=1. pause=0 -> exactly one frame runs promptly.
- resetn=0 asserted asynchronously mid-DRAW (between clk edges) -> outputs at reset values before next edge; frame_cnt=0, state=0.

Source files
------------

// File: rtl/frame_scheduler.sv
// Frame sequencer for the wall-scroller: divides clk into frame ticks and walks each tick
// through PHYS1 -> PHYS2 -> SETUP -> DRAW, with a draw watchdog and sticky status flags.
module frame_scheduler #(
  parameter int unsigned TICK_DIV     = 833333,
  parameter int unsigned CNT_W        = 20,
  parameter int unsigned DRAW_TIMEOUT = 20000,
  parameter int unsigned TO_W         = 15
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        go_i,
  input  logic        pause_i,
  input  logic        endgame_i,
  input  logic        draw_done_i,
  output logic        menu_o,
  output logic        physics_o,
  output logic        setup_o,
  output logic        display_o,
  output logic        draw_start_o,
  output logic        timeout_err_o,
  output logic        frame_miss_o,
  output logic [15:0] frame_cnt_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWait  = 3'd1,
    StPhys1 = 3'd2,
    StPhys2 = 3'd3,
    StSetup = 3'd4,
    StDraw  = 3'd5,
    StOver  = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] TickLast = CNT_W'(TICK_DIV - 1);
  localparam logic [TO_W-1:0]  WdLast   = TO_W'(DRAW_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TO_W-1:0]   wd_q, wd_d;
  logic              pend_q, pend_d;
  logic              miss_q, miss_d;
  logic              terr_q, terr_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              menu_q, physics_q, setup_q, display_q, draw_start_q;

  logic tick, start, advance;

  always_comb begin
    tick    = (cnt_q == TickLast);
    start   = (state_q == StIdle) && go_i;
    advance = (state_q == StWait) && go_i && !pause_i && pend_q;

    state_d     = state_q;
    wd_d        = '0;
    terr_d      = terr_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      StIdle:  if (go_i) state_d = StWait;
      StWait: begin
        if (!go_i) begin
          state_d = StIdle;
        end else if (advance) begin
          state_d = StPhys1;
        end
      end
      StPhys1: state_d = StPhys2;
      StPhys2: state_d = endgame_i ? StOver : StSetup;
      StSetup: state_d = StDraw;
      StDraw: begin
        // draw_done wins over a watchdog expiry in the same cycle
        if (draw_done_i) begin
          state_d     = StWait;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else if (wd_q == WdLast) begin
          state_d = StWait;
          terr_d  = 1'b1;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end
      StOver:  if (!go_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
    miss_d = miss_q | (tick & pend_q & ~advance);
    if (tick) begin
      pend_d = 1'b1;
    end else if (advance) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end

    // A fresh run starts with a clean tick phase and clean status
    if (start) begin
      cnt_d       = '0;
      pend_d      = 1'b0;
      miss_d      = 1'b0;
      terr_d      = 1'b0;
      frame_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      wd_q         <= '0;
      pend_q       <= 1'b0;
      miss_q       <= 1'b0;
      terr_q       <= 1'b0;
      frame_cnt_q  <= '0;
      menu_q       <= 1'b1;
      physics_q    <= 1'b0;
      setup_q      <= 1'b0;
      display_q    <= 1'b0;
      draw_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wd_q         <= wd_d;
      pend_q       <= pend_d;
      miss_q       <= miss_d;
      terr_q       <= terr_d;
      frame_cnt_q  <= frame_cnt_d;
      menu_q       <= (state_d == StIdle) || (state_d == StOver);
      physics_q    <= (state_d == StPhys1) || (state_d == StPhys2);
      setup_q      <= (state_d == StSetup);
      display_q    <= (state_d == StDraw);
      draw_start_q <= (state_q == StSetup);
    end
  end

  assign menu_o        = menu_q;
  assign physics_o     = physics_q;
  assign setup_o       = setup_q;
  assign display_o     = display_q;
  assign draw_start_o  = draw_start_q;
  assign timeout_err_o = terr_q;
  assign frame_miss_o  = miss_q;
  assign frame_cnt_o   = frame_cnt_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler: directed scenarios plus random stimulus, all checked each cycle
// against a cycle-level behavioural model of the sequencer rules.
module tb_frame_scheduler;

  localparam int TickDiv     = 8;
  localparam int DrawTimeout = 16;

  localparam int MIdle  = 0;
  localparam int MWait  = 1;
  localparam int MPhys1 = 2;
  localparam int MPhys2 = 3;
  localparam int MSetup = 4;
  localparam int MDraw  = 5;
  localparam int MOver  = 6;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        go = 1'b0;
  logic        pause = 1'b0;
  logic        endgame = 1'b0;
  logic        draw_done = 1'b0;
  logic        menu, physics, setup, display, draw_start, timeout_err, frame_miss;
  logic [15:0] frame_cnt;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  frame_scheduler #(
    .TICK_DIV    (TickDiv),
    .CNT_W       (3),
    .DRAW_TIMEOUT(DrawTimeout),
    .TO_W        (5)
  ) dut (
    .clk_i        (clk),
    .resetn_i     (resetn),
    .go_i         (go),
    .pause_i      (pause),
    .endgame_i    (endgame),
    .draw_done_i  (draw_done),
    .menu_o       (menu),
    .physics_o    (physics),
    .setup_o      (setup),
    .display_o    (display),
    .draw_start_o (draw_start),
    .timeout_err_o(timeout_err),
    .frame_miss_o (frame_miss),
    .frame_cnt_o  (frame_cnt),
    .state_o      (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model state: cycles since reset/start, phase, flags, and DRAW cycles spent this frame
  int m_state = MIdle;
  int m_cyc   = 0;
  int m_dcyc  = 0;
  int m_fcnt  = 0;
  bit m_pend  = 1'b0;
  bit m_miss  = 1'b0;
  bit m_terr  = 1'b0;
  bit m_dstart = 1'b0;

  initial begin
    bit tick, start, adv;
    int nxt;
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        m_state = MIdle; m_cyc = 0; m_dcyc = 0; m_fcnt = 0;
        m_pend = 0; m_miss = 0; m_terr = 0; m_dstart = 0;
      end else begin
        tick  = (m_cyc % TickDiv) == TickDiv - 1;
        start = (m_state == MIdle) && go;
        adv   = (m_state == MWait) && go && !pause && m_pend;
        m_dstart = (m_state == MSetup);
        nxt = m_state;
        case (m_state)
          MIdle:  if (go) nxt = MWait;
          MWait:  if (!go) nxt = MIdle; else if (adv) nxt = MPhys1;
          MPhys1: nxt = MPhys2;
          MPhys2: nxt = endgame ? MOver : MSetup;
          MSetup: begin nxt = MDraw; m_dcyc = 0; end
          MDraw: begin
            if (draw_done) begin
              nxt = MWait;
              m_fcnt = (m_fcnt + 1) % 65536;
            end else if (m_dcyc == DrawTimeout - 1) begin
              nxt = MWait;
              m_terr = 1;
            end else begin
              m_dcyc++;
            end
          end
          MOver:  if (!go) nxt = MIdle;
          default: nxt = MIdle;
        endcase
        if (start) begin
          m_cyc = 0; m_pend = 0; m_miss = 0; m_terr = 0; m_fcnt = 0;
        end else begin
          m_cyc++;
          if (tick && m_pend && !adv) m_miss = 1;
          if (tick) m_pend = 1;
          else if (adv) m_pend = 0;
        end
        m_state = nxt;
      end
    end
  end

  always @(negedge clk) begin
    check("menu",        16'(menu),        16'(m_state == MIdle || m_state == MOver));
    check("physics",     16'(physics),     16'(m_state == MPhys1 || m_state == MPhys2));
    check("setup",       16'(setup),       16'(m_state == MSetup));
    check("display",     16'(display),     16'(m_state == MDraw));
    check("draw_start",  16'(draw_start),  16'(m_dstart));
    check("timeout_err", 16'(timeout_err), 16'(m_terr));
    check("frame_miss",  16'(frame_miss),  16'(m_miss));
    check("frame_cnt",   frame_cnt,        16'(m_fcnt));
    check("state",       16'(state),       16'(m_state));
  end

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 16'(state), 16'(s));
  endtask

  task automatic draw_len(output int n);
    n = 0;
    while (display === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic restart();
    go = 1'b0;
    @(negedge clk);
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    check("rst_state", 16'(state), 16'd0);
    check("rst_menu", 16'(menu), 16'd1);
    check("rst_fcnt", frame_cnt, 16'd0);

    // First frame: tick latency and phase sequence
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    check("go_state", 16'(state), 16'd1);
    check("go_menu", 16'(menu), 16'd0);
    repeat (8) @(negedge clk);
    check("pre_tick_phys", 16'(physics), 16'd0);
    @(negedge clk);
    check("phys1", 16'(state), 16'd2);
    @(negedge clk);
    check("phys2", 16'(physics), 16'd1);
    @(negedge clk);
    check("setup_lvl", 16'(setup), 16'd1);
    @(negedge clk);
    check("draw_lvl", 16'(display), 16'd1);
    check("draw_start_hi", 16'(draw_start), 16'd1);
    @(negedge clk);
    check("draw_start_lo", 16'(draw_start), 16'd0);
    @(negedge clk);
    draw_done = 1'b1;
    @(negedge clk);
    draw_done = 1'b0;
    check("f1_state", 16'(state), 16'd1);
    check("f1_fcnt", frame_cnt, 16'd1);

    // Endgame into OVER, held while go stays high
    endgame = 1'b1;
    wait_state(3'd6, 40, "over_reach");
    check("over_menu", 16'(menu), 16'd1);
    repeat (20) @(negedge clk);
    check("over_hold", 16'(state), 16'd6);
    go = 1'b0;
    @(negedge clk);
    check("over_exit", 16'(state), 16'd0);
    endgame = 1'b0;

    // Draw watchdog expiry, then a completed frame
    go = 1'b1;
    wait_state(3'd5, 40, "to_draw");
    draw_len(n);
    check("to_len", 16'(n), 16'd16);
    check("to_err", 16'(timeout_err), 16'd1);
    check("to_fcnt", frame_cnt, 16'd0);
    wait_state(3'd5, 40, "to_draw2");
    draw_done = 1'b1;
    @(negedge clk);
    draw_done = 1'b0;
    check("to_fcnt2", frame_cnt, 16'd1);
    check("to_sticky", 16'(timeout_err), 16'd1);

    // Long draw spans two ticks: miss flagged, next frame starts at once
    restart();
    check("restart_err", 16'(timeout_err), 16'd0);
    wait_state(3'd5, 40, "miss_draw");
    draw_len(n);
    check("miss_flag", 16'(frame_miss), 16'd1);
    check("miss_wait", 16'(state), 16'd1);
    @(negedge clk);
    check("miss_next", 16'(state), 16'd2);

    // Pause across three ticks, then exactly one frame
    go = 1'b0;
    @(negedge clk);
    @(negedge clk);
    go = 1'b1;
    pause = 1'b1;
    @(negedge clk);
    n = 0;
    repeat (26) begin
      @(negedge clk);
      if (physics === 1'b1) n++;
    end
    check("pause_nophys", 16'(n), 16'd0);
    check("pause_miss", 16'(frame_miss), 16'd1);
    pause = 1'b0;
    @(negedge clk);
    check("unpause_phys", 16'(physics), 16'd1);
    wait_state(3'd5, 10, "unpause_draw");
    draw_done = 1'b1;
    @(negedge clk);
    draw_done = 1'b0;
    check("unpause_fcnt", frame_cnt, 16'd1);
    check("unpause_wait", 16'(state), 16'd1);

    // Asynchronous reset in the middle of DRAW
    wait_state(3'd5, 40, "ar_draw");
    #2 resetn = 1'b0;
    #1;
    check("ar_state", 16'(state), 16'd0);
    check("ar_fcnt", frame_cnt, 16'd0);
    check("ar_menu", 16'(menu), 16'd1);
    check("ar_display", 16'(display), 16'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      go        = ($urandom_range(15) != 0);
      pause     = ($urandom_range(7) == 0);
      endgame   = ($urandom_range(3) == 0);
      draw_done = ($urandom_range(5) == 0);
      if ($urandom_range(999) == 0) begin
        #3 resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
      end
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL global_timeout: simulation did not finish in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
